ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_if.sv | 18 +
 rtl/ps2_key_decoder.sv | 151 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_key_decoder_if : raw PS/2 lines in, decoded key event out       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  modport master (output ps2_clk, output ps2_data,
                  input ps2_key, input key_strobe, input frame_err);
  modport slave  (input ps2_clk, input ps2_data,
                  output ps2_key, output key_strobe, output frame_err);
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_key_decoder : PS/2 frame receiver with E0/F0/E1 prefix decode   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module ps2_key_decoder #(
  parameter int FILT    = 16,
  parameter int TIMEOUT = 49152
) (
  input  logic             clk_49m,
  input  logic             reset,
  ps2_key_decoder_if.slave bus
);
  localparam int FW = (FILT > 1) ? $clog2(FILT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [FW-1:0] c_FILT_LAST = FW'(FILT - 1);
  localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_ext;
  logic          r_rel;
  logic [2:0]    r_skip;
  logic [10:0]   r_key;
  logic          r_key_strobe;
  logic          r_frame_err;

  logic w_edge;
  logic w_data;
  logic w_odd;
  logic w_timeout;

  // The edge is the very cycle the filter accepts a 1->0 transition.
  assign w_edge    = r_clk_filt & ~r_clk_sync[1] & (r_filt_cnt == c_FILT_LAST);
  assign w_data    = r_data_sync[1];
  assign w_odd     = ^{r_shift, r_parity};
  assign w_timeout = (r_state != c_IDLE) && !w_edge && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      r_clk_sync   <= 2'b11;
      r_data_sync  <= 2'b11;
      r_clk_filt   <= 1'b1;
      r_filt_cnt   <= '0;
      r_state      <= c_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      r_skip       <= '0;
      r_key        <= '0;
      r_key_strobe <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], bus.ps2_clk};
      r_data_sync  <= {r_data_sync[0], bus.ps2_data};
      r_key_strobe <= 1'b0;
      r_frame_err  <= 1'b0;

      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_LAST) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end

      if (r_state == c_IDLE || w_edge) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + 1'b1;

      case (r_state)
        c_IDLE: begin
          if (w_edge && !w_data) begin
            r_state   <= c_SHIFT;
            r_bit_cnt <= '0;
          end
        end
        c_SHIFT: begin
          if (w_edge) begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= c_PARITY;
          end
        end
        c_PARITY: begin
          if (w_edge) begin
            r_parity <= w_data;
            r_state  <= c_STOP;
          end
        end
        c_STOP: begin
          if (w_edge) begin
            r_state <= c_IDLE;
            if (w_data && w_odd) begin
              if (r_skip != 3'd0) begin
                r_skip <= r_skip - 1'b1;
              end else if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
              end else if (r_shift == 8'hF0) begin
                r_rel <= 1'b1;
              end else if (r_shift == 8'hE1) begin
                r_skip <= 3'd7;
              end else begin
                r_key        <= {~r_key[10], ~r_rel, r_ext, r_shift};
                r_key_strobe <= 1'b1;
                r_ext        <= 1'b0;
                r_rel        <= 1'b0;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_ext       <= 1'b0;
              r_rel       <= 1'b0;
              r_skip      <= '0;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase

      // A stalled keyboard abandons the partial frame like a bad frame.
      if (w_timeout) begin
        r_state     <= c_IDLE;
        r_frame_err <= 1'b1;
        r_ext       <= 1'b0;
        r_rel       <= 1'b0;
        r_skip      <= '0;
        r_to_cnt    <= '0;
      end
    end
  end

  assign bus.ps2_key    = r_key;
  assign bus.key_strobe = r_key_strobe;
  assign bus.frame_err  = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_key_decoder : randomized frames against a byte-level model   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_ps2_key_decoder;
  localparam int FILT    = 16;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 25;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus ();
  ps2_key_decoder #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_49m (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;
  int errs        = 0;

  // Byte-level model: prefix flags, skip count, the key to expect next.
  logic [10:0] m_key  = '0;
  logic [10:0] held   = '0;
  bit          m_ext  = 1'b0;
  bit          m_rel  = 1'b0;
  int          m_skip = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      held = '0;
    end else begin
      if (bus.frame_err === 1'b1) errs++;
      if (bus.key_strobe === 1'b1) begin
        strobes++;
        check("strobe_key", {21'd0, bus.ps2_key}, {21'd0, m_key});
        held = m_key;
      end else begin
        check("key_hold", {21'd0, bus.ps2_key}, {21'd0, held});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit valid, output int es, output int ee);
    es = 0;
    ee = 0;
    if (!valid) begin
      ee = 1; m_ext = 0; m_rel = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else begin
      m_key = {~m_key[10], ~m_rel, m_ext, b};
      m_ext = 0; m_rel = 0; es = 1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      cyc(HALF);
      bus.ps2_clk = 1'b0;
      cyc(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int es, ee, s0, e0;
    model_byte(b, !(bad_par || bad_stop), es, ee);
    s0 = strobes;
    e0 = errs;
    send_bits(b, bad_par, bad_stop, 11);
    cyc(40);
    check("strobe_count", strobes - s0, es);
    check("err_count", errs - e0, ee);
  endtask

  initial begin
    int s0, e0, es, ee, r;
    logic [7:0] b;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    cyc(5);
    check("reset_key", {21'd0, bus.ps2_key}, 32'h0);
    check("reset_strobe", {31'd0, bus.key_strobe}, 32'h0);
    check("reset_err", {31'd0, bus.frame_err}, 32'h0);
    reset = 1'b1;
    cyc(10);

    frame(8'h1C, 0, 0);
    check("pin_A_press", {21'd0, bus.ps2_key}, 32'h61C);
    frame(8'hF0, 0, 0);
    frame(8'h1C, 0, 0);
    check("pin_A_release", {21'd0, bus.ps2_key}, 32'h01C);
    frame(8'hE0, 0, 0);
    frame(8'hF0, 0, 0);
    frame(8'h75, 0, 0);
    check("pin_ext_release", {21'd0, bus.ps2_key}, 32'h575);
    frame(8'h1C, 1, 0);
    check("pin_parity_hold", {21'd0, bus.ps2_key}, 32'h575);
    frame(8'h16, 0, 0);
    check("pin_after_err", {21'd0, bus.ps2_key}, 32'h216);

    // Stall after four data bits until the abort fires.
    s0 = strobes; e0 = errs;
    model_byte(8'h00, 0, es, ee);
    send_bits(8'h1C, 0, 0, 5);
    cyc(TIMEOUT + 100);
    check("timeout_err", errs - e0, 32'd1);
    check("timeout_strobe", strobes - s0, 32'd0);
    frame(8'h29, 0, 0);
    check("pin_after_timeout", {21'd0, bus.ps2_key}, 32'h629);

    // A short low glitch with data low must not start a frame.
    s0 = strobes; e0 = errs;
    bus.ps2_data = 1'b0;
    bus.ps2_clk  = 1'b0;
    cyc(10);
    bus.ps2_clk  = 1'b1;
    cyc(TIMEOUT + 100);
    bus.ps2_data = 1'b1;
    check("glitch_err", errs - e0, 32'd0);
    check("glitch_strobe", strobes - s0, 32'd0);

    frame(8'hE1, 0, 0);
    frame(8'h14, 0, 0); frame(8'h77, 0, 0); frame(8'hE1, 0, 0); frame(8'hF0, 0, 0);
    frame(8'h14, 0, 0); frame(8'hF0, 0, 0); frame(8'h77, 0, 0);
    frame(8'h16, 0, 0);
    check("pin_after_pause", {21'd0, bus.ps2_key}, 32'h216);

    // Reset in the middle of a frame.
    s0 = strobes; e0 = errs;
    send_bits(8'h1C, 0, 0, 6);
    cyc(5);
    reset = 1'b0;
    m_key = '0; m_ext = 0; m_rel = 0; m_skip = 0;
    cyc(3);
    reset = 1'b1;
    cyc(HALF * 4);
    check("midreset_strobe", strobes - s0, 32'd0);
    check("midreset_err", errs - e0, 32'd0);
    check("midreset_key", {21'd0, bus.ps2_key}, 32'h0);
    frame(8'h1C, 0, 0);
    check("pin_after_reset", {21'd0, bus.ps2_key}, 32'h61C);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2) b = 8'hE1;
      else             b = 8'($urandom);
      r = $urandom_range(0, 9);
      frame(b, r == 0, r == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
